// File: rtl/uno_pkg.sv
// rtl/uno_pkg.sv - shared UNO card types and constants
//
// Purpose: card encoding shared by the deck, discard pile and player hand.
//   card_t  : [5:4] colour, [3:0] value
//   colours : RED, YELLOW, GREEN, BLUE
//   values  : 0-9 numeric, V_SKIP..V_WILD4 action cards
//   DECK_SIZE: cards in a full UNO deck
// Ports: none (package).
package uno_pkg;

  typedef struct packed {
    logic [1:0] colour;
    logic [3:0] value;
  } card_t;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;
  localparam logic [1:0] BLUE   = 2'd3;

  localparam logic [3:0] V_SKIP  = 4'd10;
  localparam logic [3:0] V_REV   = 4'd11;
  localparam logic [3:0] V_DRAW2 = 4'd12;
  localparam logic [3:0] V_WILD  = 4'd13;
  localparam logic [3:0] V_WILD4 = 4'd14;

  localparam int DECK_SIZE = 108;

  // Wild cards carry no meaningful colour until one is declared.
  function automatic logic is_wild(card_t c);
    return (c.value == V_WILD) || (c.value == V_WILD4);
  endfunction

endpackage

// File: rtl/card_stack_ram.sv
// rtl/card_stack_ram.sv - DEPTH x CARD_W card store used as a stack
//
// Purpose: plain card memory with one synchronous write port, one
//   combinational read port and a combinational view of the top entry
//   (entry i_count-1). Contents are not reset.
// Ports:
//   i_clk     clock
//   i_we      write enable
//   i_waddr   write index
//   i_wdata   card to write
//   i_raddr   read index
//   o_rdata   card at i_raddr
//   i_count   entries held; selects the top entry
//   o_top     card at i_count-1, zero when i_count==0
module card_stack_ram #(
  parameter int DEPTH  = 108,
  parameter int CARD_W = 6,
  parameter int PTR_W  = 7
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [PTR_W-1:0]  i_waddr,
  input  logic [CARD_W-1:0] i_wdata,
  input  logic [PTR_W-1:0]  i_raddr,
  output logic [CARD_W-1:0] o_rdata,
  input  logic [PTR_W-1:0]  i_count,
  output logic [CARD_W-1:0] o_top
);

  logic [CARD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  top_idx;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign top_idx = i_count - PTR_W'(1);
  assign o_rdata = mem[i_raddr];
  assign o_top   = (i_count == '0) ? '0 : mem[top_idx];

endmodule

// File: rtl/discard_pile.sv
// rtl/discard_pile.sv - discard pile with deck refill sequencer
//
// Purpose: stacks every played card, presents the top card, and when the
//   deck runs empty streams all cards but the top one into the deck's
//   insert interface, two cycles per card, then holds until the deck has
//   cards again.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_clear             synchronous empty of the pile (new game)
//   i_play, i_play_card play strobe and card, taken when o_play_ready
//   o_play_ready        idle and not full
//   o_top_card          current top card, o_top_valid when pile non-empty
//   o_count             cards held
//   i_deck_empty        deck low-card flag
//   o_in_use            to deck; low while cards are being handed back
//   o_insert            to deck; one-cycle pulse per card
//   o_insert_card       to deck; card carried by o_insert
//   o_busy              refill sequence active
//   o_refill_done       one-cycle pulse as the refill completes
//   o_starved           deck empty but too few cards here to refill
module discard_pile
  import uno_pkg::*;
#(
  parameter int DEPTH  = DECK_SIZE,
  parameter int CARD_W = 6,
  parameter int PTR_W  = 7
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_play,
  input  logic [CARD_W-1:0] i_play_card,
  output logic              o_play_ready,
  output logic [CARD_W-1:0] o_top_card,
  output logic              o_top_valid,
  output logic [PTR_W-1:0]  o_count,
  input  logic              i_deck_empty,
  output logic              o_in_use,
  output logic              o_insert,
  output logic [CARD_W-1:0] o_insert_card,
  output logic              o_busy,
  output logic              o_refill_done,
  output logic              o_starved
);

  typedef logic [2:0] discard_state_e;

  localparam discard_state_e S_IDLE    = 3'd0;
  localparam discard_state_e S_RELEASE = 3'd1;
  localparam discard_state_e S_PUSH    = 3'd2;
  localparam discard_state_e S_GAP     = 3'd3;
  localparam discard_state_e S_FINISH  = 3'd4;
  localparam discard_state_e S_HOLD    = 3'd5;

  localparam logic [PTR_W-1:0] FULL_COUNT = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE        = PTR_W'(1);
  localparam logic [PTR_W-1:0] TWO        = PTR_W'(2);

  discard_state_e    state_q;
  logic [PTR_W-1:0]  count_q;
  logic [PTR_W-1:0]  idx_q;
  logic [CARD_W-1:0] top_card_q;

  logic              play_acc;
  logic [PTR_W-1:0]  count_after_play;
  logic              start_refill;
  logic [PTR_W-1:0]  idx_inc;
  logic              last_card;

  logic              ram_we;
  logic [PTR_W-1:0]  ram_waddr;
  logic [CARD_W-1:0] ram_wdata;
  logic [CARD_W-1:0] ram_rdata;
  logic [CARD_W-1:0] ram_top;

  card_stack_ram #(
    .DEPTH  (DEPTH),
    .CARD_W (CARD_W),
    .PTR_W  (PTR_W)
  ) u_stack (
    .i_clk   (i_clk),
    .i_we    (ram_we),
    .i_waddr (ram_waddr),
    .i_wdata (ram_wdata),
    .i_raddr (idx_q),
    .o_rdata (ram_rdata),
    .i_count (count_q),
    .o_top   (ram_top)
  );

  assign o_play_ready = (state_q == S_IDLE) && (count_q < FULL_COUNT);
  assign play_acc     = i_play && o_play_ready && !i_clear;

  // A play in the same cycle as the empty flag counts toward the refill,
  // so the freshly played card becomes the surviving top.
  assign count_after_play = count_q + PTR_W'(play_acc);
  assign start_refill     = (state_q == S_IDLE) && i_deck_empty && (count_after_play >= TWO);

  assign idx_inc   = idx_q + ONE;
  assign last_card = (idx_inc == (count_q - ONE));

  // Writes: new card onto the stack, or the old top moved down to slot 0
  // when the refill hands everything below it back to the deck.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = count_q;
    ram_wdata = i_play_card;
    if (!i_clear) begin
      if (state_q == S_FINISH) begin
        ram_we    = 1'b1;
        ram_waddr = '0;
        ram_wdata = ram_top;
      end else if (play_acc) begin
        ram_we = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      idx_q      <= '0;
      top_card_q <= '0;
    end else if (i_clear) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      idx_q      <= '0;
      top_card_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (play_acc) begin
            count_q    <= count_after_play;
            top_card_q <= i_play_card;
          end
          if (start_refill) begin
            state_q <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          idx_q   <= '0;
          state_q <= S_PUSH;
        end
        S_PUSH: begin
          state_q <= S_GAP;
        end
        S_GAP: begin
          idx_q   <= idx_inc;
          state_q <= last_card ? S_FINISH : S_PUSH;
        end
        S_FINISH: begin
          // Top card already sits in top_card_q; only the count collapses.
          count_q <= ONE;
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          // Wait for the deck to report cards so the refill cannot re-fire.
          if (!i_deck_empty) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_top_card    = top_card_q;
  assign o_top_valid   = (count_q != '0);
  assign o_count       = count_q;
  assign o_in_use      = !((state_q == S_RELEASE) || (state_q == S_PUSH) || (state_q == S_GAP));
  // A clear landing on a push or finish cycle suppresses that pulse.
  assign o_insert      = (state_q == S_PUSH) && !i_clear;
  assign o_insert_card = (state_q == S_PUSH) ? ram_rdata : '0;
  assign o_busy        = (state_q != S_IDLE);
  assign o_refill_done = (state_q == S_FINISH) && !i_clear;
  assign o_starved     = (state_q == S_IDLE) && i_deck_empty && (count_q < TWO);

endmodule

// File: tb/tb_discard_pile.sv
// tb/tb_discard_pile.sv - directed self-checking bench for discard_pile
module tb_discard_pile;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_clear;
  logic       i_play;
  logic [5:0] i_play_card;
  logic       i_deck_empty;
  logic       o_play_ready;
  logic [5:0] o_top_card;
  logic       o_top_valid;
  logic [6:0] o_count;
  logic       o_in_use;
  logic       o_insert;
  logic [5:0] o_insert_card;
  logic       o_busy;
  logic       o_refill_done;
  logic       o_starved;

  int total = 0;
  int bad   = 0;

  int         ins_n;
  int         ins_at [4];
  logic [5:0] ins_card [4];
  int         inuse_low;
  int         done_n;
  int         done_at;
  logic       stable;

  discard_pile #(.DEPTH(108), .CARD_W(6), .PTR_W(7)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_clear       (i_clear),
    .i_play        (i_play),
    .i_play_card   (i_play_card),
    .o_play_ready  (o_play_ready),
    .o_top_card    (o_top_card),
    .o_top_valid   (o_top_valid),
    .o_count       (o_count),
    .i_deck_empty  (i_deck_empty),
    .o_in_use      (o_in_use),
    .o_insert      (o_insert),
    .o_insert_card (o_insert_card),
    .o_busy        (o_busy),
    .o_refill_done (o_refill_done),
    .o_starved     (o_starved)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic play(input logic [5:0] c);
    i_play      = 1'b1;
    i_play_card = c;
    tick();
    i_play      = 1'b0;
  endtask

  task automatic clear_pile();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
  endtask

  task automatic reset_log();
    ins_n     = 0;
    inuse_low = 0;
    done_n    = 0;
    done_at   = -1;
    stable    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ins_at[k]   = -1;
      ins_card[k] = '0;
    end
  endtask

  task automatic log_cycle(input int c);
    if (o_insert) begin
      if (ins_n < 4) begin
        ins_at[ins_n]   = c;
        ins_card[ins_n] = o_insert_card;
      end
      ins_n++;
    end
    if (!o_in_use) inuse_low++;
    if (o_refill_done) begin
      done_n++;
      done_at = c;
    end
  endtask

  initial begin
    i_rst = 1'b1; i_clear = 1'b0; i_play = 1'b0; i_play_card = '0; i_deck_empty = 1'b0;
    tick();
    tick();
    chk("rst_top_valid", 32'(o_top_valid), 32'd0);
    chk("rst_top_card", 32'(o_top_card), 32'h00);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_in_use", 32'(o_in_use), 32'd1);
    chk("rst_insert", 32'(o_insert), 32'd0);
    chk("rst_done", 32'(o_refill_done), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    i_rst = 1'b0;
    tick();
    chk("idle_ready", 32'(o_play_ready), 32'd1);

    // 1: single play
    play(6'h05);
    chk("t1_top", 32'(o_top_card), 32'h05);
    chk("t1_valid", 32'(o_top_valid), 32'd1);
    chk("t1_count", 32'(o_count), 32'd1);

    // 2: four cards then refill
    clear_pile();
    play(6'h05); play(6'h19); play(6'h2C); play(6'h3D);
    chk("t2_count4", 32'(o_count), 32'd4);
    chk("t2_top4", 32'(o_top_card), 32'h3D);
    i_deck_empty = 1'b1;
    reset_log();
    for (int c = 1; c <= 10; c++) begin
      tick();
      log_cycle(c);
      if (c <= 8 && (o_count != 7'd4 || o_top_card != 6'h3D)) stable = 1'b0;
    end
    chk("t2_ins_n", 32'(ins_n), 32'd3);
    chk("t2_card0", 32'(ins_card[0]), 32'h05);
    chk("t2_card1", 32'(ins_card[1]), 32'h19);
    chk("t2_card2", 32'(ins_card[2]), 32'h2C);
    chk("t2_at0", 32'(ins_at[0]), 32'd2);
    chk("t2_at1", 32'(ins_at[1]), 32'd4);
    chk("t2_at2", 32'(ins_at[2]), 32'd6);
    chk("t2_inuse_low", 32'(inuse_low), 32'd7);
    chk("t2_done_n", 32'(done_n), 32'd1);
    chk("t2_done_at", 32'(done_at), 32'd8);
    chk("t2_stable", 32'(stable), 32'd1);
    chk("t2_count1", 32'(o_count), 32'd1);
    chk("t2_top_after", 32'(o_top_card), 32'h3D);

    // 3: hold while deck still empty
    chk("t3_busy", 32'(o_busy), 32'd1);
    chk("t3_ready", 32'(o_play_ready), 32'd0);
    play(6'h11);
    chk("t3_blocked_count", 32'(o_count), 32'd1);
    chk("t3_blocked_top", 32'(o_top_card), 32'h3D);
    chk("t3_no_insert", 32'(o_insert), 32'd0);
    i_deck_empty = 1'b0;
    tick();
    chk("t3_ready_again", 32'(o_play_ready), 32'd1);
    chk("t3_idle", 32'(o_busy), 32'd0);

    // 4: starved with one card, then a play starts a one-card refill
    clear_pile();
    play(6'h21);
    i_deck_empty = 1'b1;
    #1;
    chk("t4_starved", 32'(o_starved), 32'd1);
    chk("t4_in_use", 32'(o_in_use), 32'd1);
    tick();
    tick();
    chk("t4_still_idle", 32'(o_busy), 32'd0);
    chk("t4_no_insert", 32'(o_insert), 32'd0);
    chk("t4_starved2", 32'(o_starved), 32'd1);
    play(6'h32);
    chk("t4_release_in_use", 32'(o_in_use), 32'd0);
    chk("t4_count2", 32'(o_count), 32'd2);
    reset_log();
    for (int c = 1; c <= 6; c++) begin
      tick();
      log_cycle(c);
    end
    chk("t4_ins_n", 32'(ins_n), 32'd1);
    chk("t4_card", 32'(ins_card[0]), 32'h21);
    chk("t4_inuse_low", 32'(inuse_low), 32'd2);
    chk("t4_done_n", 32'(done_n), 32'd1);
    chk("t4_count1", 32'(o_count), 32'd1);
    chk("t4_top", 32'(o_top_card), 32'h32);
    i_deck_empty = 1'b0;
    tick();

    // 5: fill to capacity
    clear_pile();
    for (int i = 0; i < 108; i++) begin
      logic [6:0] iv;
      iv = 7'(i);
      play({iv[1:0], 4'(i % 15)});
    end
    chk("t5_count", 32'(o_count), 32'd108);
    chk("t5_ready", 32'(o_play_ready), 32'd0);
    chk("t5_top", 32'(o_top_card), 32'h32);
    play(6'h0E);
    chk("t5_count_after", 32'(o_count), 32'd108);
    chk("t5_top_after", 32'(o_top_card), 32'h32);

    // 6a: clear during second push of a 50-card refill
    clear_pile();
    for (int i = 0; i < 50; i++) begin
      logic [6:0] iv;
      iv = 7'(i);
      play({iv[1:0], 4'(i % 10)});
    end
    chk("t6_count50", 32'(o_count), 32'd50);
    i_deck_empty = 1'b1;
    tick(); tick(); tick(); tick();
    chk("t6_push2", 32'(o_insert), 32'd1);
    chk("t6_push2_card", 32'(o_insert_card), 32'h11);
    i_clear = 1'b1;
    #1;
    chk("t6_insert_stops", 32'(o_insert), 32'd0);
    tick();
    i_clear = 1'b0;
    chk("t6_in_use", 32'(o_in_use), 32'd1);
    chk("t6_count0", 32'(o_count), 32'd0);
    chk("t6_valid0", 32'(o_top_valid), 32'd0);
    chk("t6_busy0", 32'(o_busy), 32'd0);
    reset_log();
    for (int c = 1; c <= 5; c++) begin
      tick();
      log_cycle(c);
    end
    chk("t6_no_more_ins", 32'(ins_n), 32'd0);
    chk("t6_no_done", 32'(done_n), 32'd0);
    i_deck_empty = 1'b0;
    tick();

    // 6b: same, aborted by asynchronous reset
    for (int i = 0; i < 50; i++) begin
      logic [6:0] iv;
      iv = 7'(i);
      play({iv[1:0], 4'(i % 10)});
    end
    i_deck_empty = 1'b1;
    tick(); tick(); tick(); tick();
    chk("t6r_push2", 32'(o_insert), 32'd1);
    #2;
    i_rst = 1'b1;
    #1;
    chk("t6r_insert_async", 32'(o_insert), 32'd0);
    chk("t6r_in_use_async", 32'(o_in_use), 32'd1);
    chk("t6r_count_async", 32'(o_count), 32'd0);
    chk("t6r_valid_async", 32'(o_top_valid), 32'd0);
    chk("t6r_busy_async", 32'(o_busy), 32'd0);
    tick();
    i_rst = 1'b0;
    reset_log();
    for (int c = 1; c <= 5; c++) begin
      tick();
      log_cycle(c);
    end
    chk("t6r_no_more_ins", 32'(ins_n), 32'd0);
    chk("t6r_no_done", 32'(done_n), 32'd0);
    chk("t6r_count", 32'(o_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/discard_pile.md
Name: discard_pile

Overview:
Stores every card played to the table, presents the current top card to game logic, and refills the draw deck when it runs low. On deck-empty it streams all discard cards except the top one into the deck's insert interface, then releases the deck to reshuffle. It sits upstream of the deck and feeds its i_in_use, i_insert and i_insert_card inputs. Card encoding is 6 bits: [5:4] colour (0 red, 1 yellow, 2 green, 3 blue), [3:0] value (0-9, 10 skip, 11 reverse, 12 draw two, 13 wild, 14 wild draw four).

Parameters:
DEPTH, 108, maximum cards held (full UNO deck)
CARD_W, 6, card width
PTR_W, 7, index/count width, must satisfy 2^PTR_W > DEPTH

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_clear  in  1  new game; synchronous empty of the pile
i_play  in  1  play strobe; accepted only when o_play_ready=1
i_play_card  in  CARD_W  card being played
o_play_ready  out  1  high only in S_IDLE with count<DEPTH
o_top_card  out  CARD_W  current top of pile
o_top_valid  out  1  pile non-empty
o_count  out  PTR_W  cards held
i_deck_empty  in  1  deck low-card flag (deck o_empty)
o_in_use  out  1  to deck i_in_use; low during refill
o_insert  out  1  to deck i_insert; one-cycle pulse per card
o_insert_card  out  CARD_W  to deck i_insert_card
o_busy  out  1  refill in progress (any state other than S_IDLE)
o_refill_done  out  1  one-cycle pulse when refill completes
o_starved  out  1  level: i_deck_empty=1 and count<2 while in S_IDLE

Behaviour:
- Reset: state S_IDLE, count=0, idx=0. Outputs: o_top_valid=0, o_top_card=0, o_in_use=1, o_insert=0, o_refill_done=0, o_busy=0. Memory contents are don't-care.
- Storage: mem[0..DEPTH-1] used as a stack. o_top_card=mem[count-1], registered alongside the write. o_top_valid=(count!=0).
- Play (S_IDLE, i_play, o_play_ready): mem[count]<=i_play_card, count<=count+1. The new top card is visible the next cycle.
- If count==DEPTH, o_play_ready=0 and i_play is ignored with no state change.
- Play while not ready: ignored.
- S_IDLE -> S_RELEASE when i_deck_empty=1 and count>=2. If i_play arrives in the same cycle, the play is accepted first; the refill then includes that card below the new top.
- S_RELEASE (1 cycle): o_in_use=0, idx<=0. -> S_PUSH.
- S_PUSH: o_in_use=0, o_insert=1, o_insert_card=mem[idx]. -> S_GAP.
- S_GAP: o_insert=0, idx<=idx+1. If idx+1==count-1 -> S_FINISH, else -> S_PUSH. Insert pulses are therefore spaced every 2 cycles, which the deck's insert handshake requires.
- S_FINISH (1 cycle): mem[0]<=mem[count-1], count<=1, o_in_use<=1, o_refill_done=1. -> S_HOLD.
- S_HOLD: o_in_use=1; plays are blocked. -> S_IDLE when i_deck_empty=0. This prevents an immediate re-trigger while the deck shuffles.
- Refill of N=count cards: exactly N-1 insert pulses. o_in_use is low from the S_RELEASE cycle through the last S_GAP cycle, i.e. 2(N-1)+1 cycles.
- The top card is never inserted; it remains at mem[0] with o_top_card unchanged.
- o_count, o_top_card and o_top_valid are stable throughout a refill until S_FINISH.
- i_clear has priority in any state. count<=0, o_top_valid<=0, o_in_use<=1, o_insert=0, and the state goes to S_IDLE next cycle. A refill aborted this way leaves o_refill_done unasserted.
- Asynchronous reset mid-refill behaves the same as i_clear, with all reset values applied immediately.
- Arithmetic: count and idx are PTR_W unsigned. count never exceeds DEPTH and never goes below 0; no wrap is possible.

Decomposition:
- Shared package uno_pkg holds:
  - card_t (6-bit packed struct: colour 2, value 4);
  - colour constants RED/YELLOW/GREEN/BLUE;
  - value constants V_SKIP=10, V_REV=11, V_DRAW2=12, V_WILD=13, V_WILD4=14;
  - DECK_SIZE=108.
- Refill state enum discard_state_e is local to the module.
- One natural sub-module: card_stack_ram (DEPTH x CARD_W).
  - One synchronous write port and one combinational read port.
  - Also exposes the top entry.
  - Reused by a future player-hand block.

Test Plan:
1. Reset, then play 0x05 (red 5) -> next cycle o_top_card=0x05, o_top_valid=1, o_count=1.
2. Play 0x05, 0x19, 0x2C, 0x3D, then i_deck_empty=1 -> expect:
   - 3 o_insert pulses carrying 0x05, 0x19, 0x2C, 2 cycles apart;
   - o_in_use low for 7 cycles;
   - o_refill_done pulse, then o_count=1, o_top_card=0x3D.
3. Hold i_deck_empty=1 after refill -> state stays in S_HOLD, no further inserts, o_play_ready=0. Drop i_deck_empty -> o_play_ready=1 the next cycle.
4. count=1 with i_deck_empty=1 -> o_starved=1, o_in_use=1, no inserts. A further play raises count to 2 and triggers a refill of exactly 1 card.
5. Fill with 108 plays -> o_play_ready=0; a 109th i_play leaves count=108 and o_top_card unchanged.
6. Assert i_clear during the second S_PUSH of a 50-card refill -> o_insert stops, o_in_use=1 and o_count=0 next cycle, no o_refill_done. Repeat with i_rst -> identical result, applied asynchronously.
